nibble_serial_adder: RTL and testbench



---
 rtl/nibble_adder_pkg.sv | 16 +
 rtl/ripple_carry_adder.sv | 21 ++
 rtl/nibble_serial_adder.sv | 115 +++++++++++
 tb/tb_nibble_serial_adder.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/nibble_adder_pkg.sv
// rtl/nibble_adder_pkg.sv - shared types and helpers for the nibble-serial adder
package nibble_adder_pkg;

  localparam int NIBBLE_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int nibbles(input int width);
    return width / NIBBLE_W;
  endfunction

endpackage

// File: rtl/ripple_carry_adder.sv
// rtl/ripple_carry_adder.sv - 4-bit ripple-carry adder exposing every bit's carry-out
module ripple_carry_adder (
  input  logic [3:0] ain,
  input  logic [3:0] bin,
  input  logic       ci,
  output logic [3:0] s,
  output logic [3:0] co
);

  logic [4:0] c;

  assign c[0] = ci;

  for (genvar i = 0; i < 4; i++) begin : g_bit
    assign s[i]   = ain[i] ^ bin[i] ^ c[i];
    assign c[i+1] = (ain[i] & bin[i]) | (c[i] & (ain[i] ^ bin[i]));
  end

  assign co = c[4:1];

endmodule

// File: rtl/nibble_serial_adder.sv
// rtl/nibble_serial_adder.sv - WIDTH-bit adder streamed LSB nibble first through one 4-bit adder
// Optional signed-overflow output out_ovf when NIBBLE_ADDER_OVF_EN is defined.
module nibble_serial_adder
  import nibble_adder_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
`ifdef NIBBLE_ADDER_OVF_EN
  output logic             out_ovf,
`endif
  output logic             out_cout
);

  localparam int NIBBLES = nibbles(WIDTH);
  localparam int CNT_W   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

  if ((WIDTH % NIBBLE_W) != 0 || WIDTH < NIBBLE_W) begin : g_width_check
    $error("nibble_serial_adder: WIDTH must be a positive multiple of 4");
  end

  state_t             state;
  logic [WIDTH-1:0]   a_sh;
  logic [WIDTH-1:0]   b_sh;
  logic [WIDTH-1:0]   sum_sh;
  logic [CNT_W-1:0]   cnt;
  logic               carry_r;
  logic [3:0]         s;
  logic [3:0]         co;
  logic [WIDTH-1:0]   sum_next;
  logic               last;
  logic [2:0]         unused_co;

  ripple_carry_adder u_rca (
    .ain (a_sh[3:0]),
    .bin (b_sh[3:0]),
    .ci  (carry_r),
    .s   (s),
    .co  (co)
  );

  assign unused_co = co[2:0];

  // New nibble enters at the top so the LSB nibble ends at bit 0 after NIBBLES shifts.
  assign sum_next = (sum_sh >> NIBBLE_W) | (WIDTH'(s) << (WIDTH - NIBBLE_W));
  assign last     = (cnt == CNT_W'(NIBBLES - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      a_sh    <= '0;
      b_sh    <= '0;
      sum_sh  <= '0;
      cnt     <= '0;
      carry_r <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_sh    <= in_a;
            b_sh    <= in_b;
            carry_r <= in_cin;
            cnt     <= '0;
            state   <= RUN;
          end
        end
        RUN: begin
          sum_sh  <= sum_next;
          carry_r <= co[3];
          a_sh    <= a_sh >> NIBBLE_W;
          b_sh    <= b_sh >> NIBBLE_W;
          cnt     <= cnt + 1'b1;
          if (last) begin
            state <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef NIBBLE_ADDER_OVF_EN
  logic ovf_r;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ovf_r <= 1'b0;
    end else if (state == RUN && last) begin
      ovf_r <= co[2] ^ co[3];
    end
  end

  assign out_ovf = ovf_r;
`endif

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign out_sum   = sum_sh;
  assign out_cout  = carry_r;

endmodule

// File: tb/tb_nibble_serial_adder.sv
// tb/tb_nibble_serial_adder.sv - scoreboard bench for nibble_serial_adder
module tb_nibble_serial_adder;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] in_a = '0;
  logic [W-1:0] in_b = '0;
  logic         in_cin = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] out_sum;
  logic         out_cout;
`ifdef NIBBLE_ADDER_OVF_EN
  logic         out_ovf;
`endif

  nibble_serial_adder #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_cin    (in_cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
`ifdef NIBBLE_ADDER_OVF_EN
    .out_ovf   (out_ovf),
`endif
    .out_cout  (out_cout)
  );

  always #5 clk = ~clk;

  // Each entry is {ovf, cout, sum}.
  logic [W+1:0] sb[$];
  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [W+1:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic cin);
    logic [W:0] t;
    logic       ovf;
    t   = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
    ovf = (a[W-1] == b[W-1]) && (t[W-1] != a[W-1]);
    return {ovf, t};
  endfunction

  task automatic check_result(input string tag, input logic [W+1:0] exp);
    check({tag, "_sum"}, out_sum, exp[W-1:0]);
    check({tag, "_cout"}, out_cout, exp[W]);
`ifdef NIBBLE_ADDER_OVF_EN
    check({tag, "_ovf"}, out_ovf, exp[W+1]);
`endif
  endtask

  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                        input int hold);
    logic [W+1:0] exp;
    int           lat;
    bit           done;
    @(negedge clk);
    check("idle_in_ready", in_ready, 1);
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    in_cin   = cin;
    sb.push_back(model(a, b, cin));
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_a     = W'($urandom);
    in_b     = W'($urandom);
    in_cin   = 1'($urandom_range(0, 1));
    // The accepting edge counts as the first edge.
    lat  = 1;
    done = 1'b0;
    while (!done && lat < 20) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (out_valid) done = 1'b1;
    end
    check("latency", lat, 5);
    exp = sb.pop_front();
    if (!done) return;
    check_result("result", exp);
    for (int h = 0; h < hold; h++) begin
      in_valid = 1'b1;
      in_a     = W'($urandom);
      in_b     = W'($urandom);
      @(posedge clk);
      @(negedge clk);
      check("bp_out_valid", out_valid, 1);
      check("bp_in_ready", in_ready, 0);
      check_result("bp_hold", exp);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    @(negedge clk);
    check("post_out_valid", out_valid, 0);
    check("post_in_ready", in_ready, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_sum", out_sum, 0);
    check("rst_out_cout", out_cout, 0);
    check("rst_in_ready", in_ready, 1);
`ifdef NIBBLE_ADDER_OVF_EN
    check("rst_out_ovf", out_ovf, 0);
`endif

    run_op(16'h0001, 16'h0003, 1'b0, 0);
    run_op(16'hFFFF, 16'h0001, 1'b0, 0);
    run_op(16'h5A5A, 16'hA5A5, 1'b1, 0);
    run_op(16'h1234, 16'h4321, 1'b1, 3);

    // Abort in the second RUN cycle; nothing may be emitted.
    @(negedge clk);
    in_valid = 1'b1;
    in_a     = 16'h1234;
    in_b     = 16'h1111;
    in_cin   = 1'b0;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("abort_out_valid", out_valid, 0);
      check("abort_in_ready", in_ready, 1);
    end
    run_op(16'h1234, 16'h1111, 1'b0, 0);

    run_op(16'h7FFF, 16'h0001, 1'b0, 0);
    run_op(16'h8000, 16'h8000, 1'b0, 1);
    for (int i = 0; i < 8; i++) begin
      run_op(W'($urandom), W'($urandom), 1'($urandom_range(0, 1)), $urandom_range(0, 2));
    end

    check("sb_empty", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
